// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_issuer
//  Description : Queues ALU commands in a small FIFO and issues each one to a
//                downstream accumulator (which has no enable) for its repeat
//                count. The outputs are driven to NOP whenever no command is
//                issuing. Pause is honoured only between commands.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_issuer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_L,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [3:0]                 in_operand,
    input  logic [1:0]                 in_repeat,
    input  logic                       pause,
    output logic [1:0]                 operation,
    output logic [3:0]                 operand,
    output logic                       issue_strobe,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop_err
);

    localparam int unsigned c_aw = $clog2(DEPTH);
    localparam int unsigned c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_depth = c_lw'(DEPTH);

    // A FIFO entry packs {op[7:6], operand[5:2], repeat[1:0]}.
    typedef logic [7:0] entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    entry_t             mem_q [DEPTH];
    logic [c_aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_lw-1:0]    level_q, level_d;
    logic [1:0]         remaining_q, remaining_d;
    logic [1:0]         operation_q, operation_d;
    logic [3:0]         operand_q, operand_d;
    logic               strobe_q, strobe_d;
    logic               drop_err_q, drop_err_d;

    logic               w_push;
    logic               w_pop;
    logic               w_boundary;
    entry_t             w_head;

    // Ready looks only at registered occupancy, so a pop never frees a slot
    // for a push in the same cycle; it is held low while reset is asserted.
    assign in_ready   = reset_L & (level_q < c_depth);
    assign w_push     = in_valid & in_ready;
    assign w_head     = mem_q[rd_ptr_q];

    // A command boundary is idle, or the last repeat of the issuing command.
    assign w_boundary = (state_q == IDLE) || (remaining_q == 2'd0);
    assign w_pop      = w_boundary && (level_q != '0) && !pause;

    assign operation    = operation_q;
    assign operand      = operand_q;
    assign issue_strobe = strobe_q;
    assign level        = level_q;
    assign drop_err     = drop_err_q;

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {in_op, in_operand, in_repeat};
        end
    end

    // FIFO pointer / occupancy update and sticky drop detection.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_err_d = drop_err_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + c_lw'(w_push) - c_lw'(w_pop);
        if (in_valid && !in_ready) begin
            drop_err_d = 1'b1;
        end
    end

    // Issue FSM next state and registered output values.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        operation_d = operation_q;
        operand_d   = operand_q;
        strobe_d    = strobe_q;
        if (w_pop) begin
            state_d     = ISSUE;
            operation_d = w_head[7:6];
            operand_d   = w_head[5:2];
            remaining_d = w_head[1:0];
            strobe_d    = 1'b1;
        end else if (w_boundary) begin
            state_d     = IDLE;
            operation_d = 2'd0;
            operand_d   = 4'd0;
            remaining_d = 2'd0;
            strobe_d    = 1'b0;
        end else begin
            remaining_d = remaining_q - 2'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            remaining_q <= 2'd0;
            operation_q <= 2'd0;
            operand_q   <= 4'd0;
            strobe_q    <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            remaining_q <= remaining_d;
            operation_q <= operation_d;
            operand_q   <= operand_d;
            strobe_q    <= strobe_d;
            drop_err_q  <= drop_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_issuer
//  Description : Self-checking bench for alu_cmd_issuer with a queue-based
//                reference model of command acceptance and issue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;

    logic       clock;
    logic       reset_L;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_operand;
    logic [1:0] in_repeat;
    logic       pause;
    logic [1:0] operation;
    logic [3:0] operand;
    logic       issue_strobe;
    logic [2:0] level;
    logic       drop_err;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted commands waiting, and the command on the
    // outputs together with how many issue cycles it still has (incl. now).
    logic [7:0] m_q[$];
    int         m_left;
    logic [1:0] m_op;
    logic [3:0] m_opnd;
    logic       m_drop;

    alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_operand   (in_operand),
        .in_repeat    (in_repeat),
        .pause        (pause),
        .operation    (operation),
        .operand      (operand),
        .issue_strobe (issue_strobe),
        .level        (level),
        .drop_err     (drop_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_q.delete();
        m_left = 0;
        m_op   = 2'd0;
        m_opnd = 4'd0;
        m_drop = 1'b0;
    endtask

    // One rising edge worth of model behaviour, using the driven inputs.
    task automatic model_edge();
        int pre;
        logic [7:0] c;
        pre = m_q.size();
        if (m_left > 1) begin
            m_left--;
        end else if (pre > 0 && !pause) begin
            c      = m_q.pop_front();
            m_op   = c[7:6];
            m_opnd = c[5:2];
            m_left = int'(c[1:0]) + 1;
        end else begin
            m_left = 0;
            m_op   = 2'd0;
            m_opnd = 4'd0;
        end
        if (in_valid) begin
            if (pre < DEPTH) m_q.push_back({in_op, in_operand, in_repeat});
            else             m_drop = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic exp_ready;
        exp_ready = reset_L && (m_q.size() < DEPTH);
        chk("in_ready", int'(in_ready), int'(exp_ready));
        chk("level", int'(level), m_q.size());
        chk("strobe", int'(issue_strobe), (m_left > 0) ? 1 : 0);
        chk("operation", int'(operation), (m_left > 0) ? int'(m_op) : 0);
        chk("operand", int'(operand), (m_left > 0) ? int'(m_opnd) : 0);
        chk("drop_err", int'(drop_err), int'(m_drop));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_L) model_edge();
        else         model_reset();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [3:0] od, input logic [1:0] rep);
        in_valid   = v;
        in_op      = op;
        in_operand = od;
        in_repeat  = rep;
    endtask

    initial begin
        // Reset state
        model_reset();
        reset_L = 1'b0;
        pause   = 1'b0;
        drive(1'b0, 2'd0, 4'd0, 2'd0);
        #3;
        check_all();
        tick();
        tick();
        reset_L = 1'b1;
        #1;
        check_all();

        // Single command, one issue cycle
        drive(1'b1, 2'd0, 4'd3, 2'd0);
        tick();
        drive(1'b0, 2'd0, 4'd0, 2'd0);
        chk("single_level1", int'(level), 1);
        tick();
        chk("single_strobe", int'(issue_strobe), 1);
        chk("single_operand", int'(operand), 3);
        chk("single_level0", int'(level), 0);
        tick();
        chk("single_nop", int'(issue_strobe), 0);

        // Repeat then back-to-back
        drive(1'b1, 2'd1, 4'd2, 2'd2);
        tick();
        drive(1'b1, 2'd3, 4'd5, 2'd0);
        tick();
        drive(1'b0, 2'd0, 4'd0, 2'd0);
        for (int i = 0; i < 6; i++) tick();

        // Full FIFO with pause, fifth command dropped
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'(i), 4'(i + 8), 2'(i));
            tick();
        end
        drive(1'b0, 2'd0, 4'd0, 2'd0);
        chk("full_level", int'(level), 4);
        chk("full_ready", int'(in_ready), 0);
        chk("full_drop", int'(drop_err), 1);
        pause = 1'b0;
        for (int i = 0; i < 14; i++) tick();

        // Pause raised during the second issue cycle
        drive(1'b1, 2'd2, 4'd9, 2'd3);
        tick();
        drive(1'b1, 2'd1, 4'd1, 2'd0);
        tick();
        drive(1'b0, 2'd0, 4'd0, 2'd0);
        tick();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pause_hold_strobe", int'(issue_strobe), 0);
        chk("pause_hold_level", int'(level), 1);
        pause = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset during the second repeat with two commands queued
        drive(1'b1, 2'd0, 4'd1, 2'd3);
        tick();
        drive(1'b1, 2'd1, 4'd6, 2'd1);
        tick();
        drive(1'b1, 2'd2, 4'd7, 2'd0);
        tick();
        drive(1'b0, 2'd0, 4'd0, 2'd0);
        chk("pre_reset_strobe", int'(issue_strobe), 1);
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("reset_nop", int'(issue_strobe), 0);
        tick();
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_nop", int'(issue_strobe), 0);
        end

        // Randomized stream with pause toggling
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 2) != 0), 2'($urandom), 4'($urandom),
                  2'($urandom));
            pause = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            assert (level <= 3'(DEPTH)) else begin
                errors++;
                $error("FAIL level_bound observed=%0d expected<=%0d", level, DEPTH);
            end
        end
        drive(1'b0, 2'd0, 4'd0, 2'd0);
        pause = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of two, 2 to 16.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_L  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  upstream command present.
REQ-005 in_ready  output  1  issuer can accept a command this cycle.
REQ-006 in_op  input  2  ALU op: 0 add, 1 subtract, 2 OR, 3 XOR.
REQ-007 in_operand  input  4  ALU operand.
REQ-008 in_repeat  input  2  issue count minus one (0 = once, 3 = four times).
REQ-009 pause  input  1  hold issue at command boundaries.
REQ-010 operation  output  2  op driven to downstream accumulator.
REQ-011 operand  output  4  operand driven to downstream accumulator.
REQ-012 issue_strobe  output  1  high when operation/operand carry a real command.
REQ-013 level  output  log2(DEPTH)+1  FIFO occupancy.
REQ-014 drop_err  output  1  sticky: a command was offered while full.

Function
REQ-015 Accept: a command SHALL be written to the FIFO tail at a rising edge where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL equal (level < DEPTH), registered occupancy only; when full, a same-cycle pop SHALL NOT enable a push.
REQ-017 Downstream accumulator has no enable; outputs SHALL be NOP (operation=0, operand=0, issue_strobe=0) in every cycle not issuing a command.
REQ-018 operation, operand, issue_strobe SHALL be registered outputs.
REQ-019 States: IDLE, ISSUE.
REQ-020 IDLE: if level>0 and pause=0 at an edge, pop head, load op/operand, load remaining=in_repeat of that entry, go ISSUE; else stay IDLE driving NOP.
REQ-021 ISSUE: outputs carry loaded op/operand with issue_strobe=1 for exactly remaining+1 consecutive cycles.
REQ-022 At the edge ending the last repeat: if level>0 and pause=0, pop and load next command (back-to-back, no NOP gap); else go IDLE, NOP next cycle.
REQ-023 pause SHALL be sampled only at command boundaries; a command in ISSUE SHALL complete all repeats regardless of pause.
REQ-024 Latency: command accepted at edge N into an empty FIFO with issuer IDLE and pause=0 SHALL be popped at edge N+1 and appear on outputs in the cycle after edge N+1.
REQ-025 Simultaneous push and pop (not full) SHALL leave level unchanged and preserve FIFO order.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-027 drop_err SHALL set at an edge where in_valid=1 and in_ready=0, and clear only by reset; the dropped command SHALL be discarded.
REQ-028 Commands SHALL issue in strict acceptance order, each exactly in_repeat+1 times.

Reset
REQ-029 reset_L=0 SHALL immediately force: state IDLE, FIFO empty, level=0, in_ready=0 during reset then 1 after release, operation=0, operand=0, issue_strobe=0, drop_err=0, remaining=0.
REQ-030 Reset mid-ISSUE SHALL abort the current command and discard all queued commands; no partial repeats resume.
REQ-031 First accept after release SHALL occur at the first rising edge with reset_L=1.

Verification
REQ-032 Single: push (op=0, operand=3, repeat=0) at edge 1 -> operation=0, operand=3, strobe=1 for one cycle after edge 2; NOP after edge 3; level 1 then 0.
REQ-033 Repeat/back-to-back: push (1,2,rep=2) then (3,5,rep=0) -> strobe high 4 consecutive cycles: (1,2)x3 then (3,5)x1, no gap.
REQ-034 Full: pause=1, push 5 commands with DEPTH=4 -> level=4, in_ready=0, fifth dropped, drop_err=1; release pause -> exactly the 4 accepted issue in order.
REQ-035 Pause boundary: push (2,9,rep=3), assert pause on second issue cycle, second command queued -> first issues 4 cycles, then NOP until pause=0.
REQ-036 Reset mid-op: reset_L low during repeat 2 of (0,1,rep=3) with 2 queued -> outputs NOP immediately, level=0, nothing issues after release.
REQ-037 Wrap: stream 20 commands with random repeats, pause toggling -> issued sequence matches scoreboard; level never exceeds 4.
